// File: rtl/i2s_pkg.sv
// i2s_pkg: shared I2S constants and types for the PCM1808 audio front end.
// Used by the I2S clock master, i2s_rx and the future i2s_tx.
//   MCLK_PER_BCLK  : mclk cycles per bit clock period
//   BCLK_PER_FRAME : bit clocks per stereo frame
//   SLOT_WIDTH     : bit clocks per channel slot
//   SAMPLE_W       : bits per PCM sample
package i2s_pkg;

  localparam int unsigned MCLK_PER_BCLK  = 4;
  localparam int unsigned BCLK_PER_FRAME = 64;
  localparam int unsigned SLOT_WIDTH     = 32;
  localparam int unsigned SAMPLE_W       = 24;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  // Explicit encodings keep the state values identical to the legacy RTL.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    RUN   = 2'd2
  } rx_state_t;

endpackage

// File: rtl/i2s_rx_sync.sv
// i2s_rx_sync: brings the I2S pad signals into the mclk domain and detects
// bit-clock rising edges and word-select transitions.
//   clk       : mclk
//   srst_n    : synchronous active-low reset
//   bclk      : raw I2S bit clock
//   lrclk     : raw I2S word select
//   dout      : raw serial data
//   bclk_rise : one-cycle pulse on each synchronized bclk rising edge
//   lr_edge   : bclk_rise where word select differs from its previous bclk_rise value
//   lrclk_cur : synchronized word select
//   dout_cur  : synchronized serial data (aligned with bclk_rise)
module i2s_rx_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic srst_n,
  input  logic bclk,
  input  logic lrclk,
  input  logic dout,
  output logic bclk_rise,
  output logic lr_edge,
  output logic lrclk_cur,
  output logic dout_cur
);

  logic [SYNC_STAGES-1:0] bclk_sr;
  logic [SYNC_STAGES-1:0] lrclk_sr;
  logic [SYNC_STAGES-1:0] dout_sr;
  logic                   bclk_d;
  logic                   lr_d;
  logic                   bclk_cur;

  assign bclk_cur  = bclk_sr[SYNC_STAGES-1];
  assign lrclk_cur = lrclk_sr[SYNC_STAGES-1];
  assign dout_cur  = dout_sr[SYNC_STAGES-1];

  assign bclk_rise = bclk_cur & ~bclk_d;
  assign lr_edge   = bclk_rise & (lrclk_cur ^ lr_d);

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      bclk_sr  <= '0;
      lrclk_sr <= '0;
      dout_sr  <= '0;
      bclk_d   <= 1'b0;
      lr_d     <= 1'b0;
    end else begin
      // Shift form works for any depth, including a single stage.
      bclk_sr  <= (bclk_sr  << 1) | SYNC_STAGES'(bclk);
      lrclk_sr <= (lrclk_sr << 1) | SYNC_STAGES'(lrclk);
      dout_sr  <= (dout_sr  << 1) | SYNC_STAGES'(dout);
      bclk_d   <= bclk_cur;
      // Word select is only meaningful at bit-clock sample points.
      if (bclk_rise) begin
        lr_d <= lrclk_cur;
      end
    end
  end

endmodule

// File: rtl/i2s_rx.sv
// i2s_rx: PCM1808 I2S receiver. Deserializes DOUT into signed left/right
// samples and presents each stereo pair with a one-cycle valid strobe.
//   mclk_i     : master clock, all logic on its rising edge
//   srst_n_i   : synchronous active-low reset
//   enable_i   : capture enable (devices-ready flag)
//   bclk_i     : I2S bit clock (mclk/4)
//   lrclk_i    : word select, 0 = left, 1 = right
//   dout_i     : ADC serial data, MSB first, one-bit I2S delay
//   left_o     : signed left sample
//   right_o    : signed right sample
//   valid_o    : one-cycle strobe, outputs stable until the next strobe
//   slot_err_o : sticky flag, a slot ended with the wrong bit count
module i2s_rx #(
  parameter int unsigned DATA_WIDTH  = 24,
  parameter int unsigned SLOT_WIDTH  = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                         mclk_i,
  input  logic                         srst_n_i,
  input  logic                         enable_i,
  input  logic                         bclk_i,
  input  logic                         lrclk_i,
  input  logic                         dout_i,
  output logic signed [DATA_WIDTH-1:0] left_o,
  output logic signed [DATA_WIDTH-1:0] right_o,
  output logic                         valid_o,
  output logic                         slot_err_o
);

  import i2s_pkg::*;

  localparam int unsigned   CW        = $clog2(SLOT_WIDTH);
  localparam logic [CW-1:0] CNT_MAX   = CW'(SLOT_WIDTH - 1);
  localparam logic [CW-1:0] LAST_DATA = CW'(DATA_WIDTH - 1);

  logic                  bclk_rise;
  logic                  lr_edge;
  logic                  lrclk_cur;
  logic                  dout_cur;

  rx_state_t             state;
  logic [CW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] word_next;
  logic [DATA_WIDTH-1:0] left_hold;
  logic [DATA_WIDTH-1:0] right_hold;
  logic                  chan;
  logic                  left_ok;
  logic                  pend;

  i2s_rx_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk       (mclk_i),
    .srst_n    (srst_n_i),
    .bclk      (bclk_i),
    .lrclk     (lrclk_i),
    .dout      (dout_i),
    .bclk_rise (bclk_rise),
    .lr_edge   (lr_edge),
    .lrclk_cur (lrclk_cur),
    .dout_cur  (dout_cur)
  );

  assign word_next = {shift_q[DATA_WIDTH-2:0], dout_cur};

  always_ff @(posedge mclk_i) begin
    if (!srst_n_i) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift_q    <= '0;
      left_hold  <= '0;
      right_hold <= '0;
      chan       <= 1'b0;
      left_ok    <= 1'b0;
      pend       <= 1'b0;
      left_o     <= '0;
      right_o    <= '0;
      valid_o    <= 1'b0;
      slot_err_o <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      if (!enable_i) begin
        // Disable overrides any word completing this cycle.
        state   <= IDLE;
        left_ok <= 1'b0;
        pend    <= 1'b0;
      end else begin
        // Publishing sits ahead of the FSM so a same-cycle set of pend wins.
        if (pend) begin
          left_o  <= left_hold;
          right_o <= right_hold;
          valid_o <= 1'b1;
          pend    <= 1'b0;
        end
        case (state)
          IDLE: state <= ALIGN;
          ALIGN: begin
            if (lr_edge && !lrclk_cur) begin
              state   <= RUN;
              bit_cnt <= '0;
              shift_q <= '0;
              chan    <= 1'b0;
              left_ok <= 1'b0;
            end
          end
          RUN: begin
            if (bclk_rise) begin
              if (lr_edge) begin
                // Slot boundary; the bit sampled here is the I2S delay bit.
                if (bit_cnt != CNT_MAX) begin
                  slot_err_o <= 1'b1;
                  state      <= ALIGN;
                  left_ok    <= 1'b0;
                end
                bit_cnt <= '0;
                shift_q <= '0;
                chan    <= lrclk_cur;
              end else begin
                if (bit_cnt != CNT_MAX) begin
                  bit_cnt <= bit_cnt + 1'b1;
                end
                if (32'(bit_cnt) < DATA_WIDTH) begin
                  shift_q <= word_next;
                end
                if (bit_cnt == LAST_DATA) begin
                  if (!chan) begin
                    left_hold <= word_next;
                    left_ok   <= 1'b1;
                  end else begin
                    right_hold <= word_next;
                    pend       <= left_ok;
                    left_ok    <= 1'b0;
                  end
                end
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: scoreboard bench for i2s_rx. An I2S BFM drives frames; frames
// whose pair must appear on the outputs are pushed at drive time and popped
// when valid_o strobes.
module tb_i2s_rx;

  import i2s_pkg::*;

  localparam int unsigned DW = 24;

  logic          mclk = 1'b0;
  logic          srst_n = 1'b0;
  logic          enable = 1'b1;
  logic          bclk = 1'b0;
  logic          lrclk = 1'b0;
  logic          dout = 1'b0;
  logic [DW-1:0] left;
  logic [DW-1:0] right;
  logic          valid;
  logic          slot_err;

  typedef struct {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
    int            gap;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   failures = 0;
  int   cycle = 0;
  int   last_valid = 0;
  logic prev_valid = 1'b0;

  i2s_rx #(
    .DATA_WIDTH  (DW),
    .SLOT_WIDTH  (32),
    .SYNC_STAGES (2)
  ) dut (
    .mclk_i     (mclk),
    .srst_n_i   (srst_n),
    .enable_i   (enable),
    .bclk_i     (bclk),
    .lrclk_i    (lrclk),
    .dout_i     (dout),
    .left_o     (left),
    .right_o    (right),
    .valid_o    (valid),
    .slot_err_o (slot_err)
  );

  always #5 mclk = ~mclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One bit: 2 mclk low then 2 mclk high; data and word select change while low.
  task automatic send_bit(input logic ch, input logic b);
    bclk  = 1'b0;
    lrclk = ch;
    dout  = b;
    repeat (2) @(negedge mclk);
    bclk = 1'b1;
    repeat (2) @(negedge mclk);
  endtask

  task automatic send_slot(input logic ch, input logic [DW-1:0] w, input logic pad, input int len);
    for (int j = 0; j < len; j++) begin
      if (j >= 1 && j <= int'(DW)) send_bit(ch, w[DW-j]);
      else                         send_bit(ch, pad);
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input logic pad,
                            input int rlen, input bit expect_out, input int gap);
    exp_t x;
    if (expect_out) begin
      x.l = l;
      x.r = r;
      x.gap = gap;
      sb.push_back(x);
    end
    send_slot(1'b0, l, pad, 32);
    send_slot(1'b1, r, pad, rlen);
  endtask

  always @(negedge mclk) begin
    cycle++;
    if (valid) begin
      check("pulse_width", prev_valid, 0);
      check("valid_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("left", left, e.l);
        check("right", right, e.r);
        if (e.gap != 0) check("valid_gap", cycle - last_valid, e.gap);
      end
      last_valid = cycle;
    end
    prev_valid = valid;
  end

  initial begin
    repeat (4) @(negedge mclk);
    check("rst_left", left, 0);
    check("rst_right", right, 0);
    check("rst_valid", valid, 0);
    check("rst_slot_err", slot_err, 0);
    check("rst_state", 32'(dut.state), 32'(IDLE));
    srst_n = 1'b1;
    repeat (2) @(negedge mclk);
    check("state_align", 32'(dut.state), 32'(ALIGN));

    // Priming frame is only used to find a left-slot start.
    send_frame(24'h111111, 24'h222222, 1'b0, 32, 1'b0, 0);
    send_frame(24'h123456, 24'hABCDEF, 1'b0, 32, 1'b1, 0);
    send_frame(24'h123456, 24'hABCDEF, 1'b0, 32, 1'b1, 256);
    send_frame(24'h800000, 24'h7FFFFF, 1'b1, 32, 1'b1, 256);

    // Enable drops one mclk before the right word would complete.
    fork
      send_frame(24'h654321, 24'hFEDCBA, 1'b0, 32, 1'b0, 0);
      begin
        repeat (227) @(negedge mclk);
        enable = 1'b0;
      end
    join
    check("drop_state", 32'(dut.state), 32'(IDLE));
    check("drop_hold_left", left, 24'h800000);
    check("drop_hold_right", right, 24'h7FFFFF);

    // Enable returns mid right slot; that frame is discarded.
    fork
      send_frame(24'h13579B, 24'h2468AC, 1'b0, 32, 1'b0, 0);
      begin
        repeat (168) @(negedge mclk);
        enable = 1'b1;
      end
    join
    send_frame(24'h5A5A5A, 24'h0F0F0F, 1'b0, 32, 1'b1, 0);
    check("no_slot_err", slot_err, 0);

    // Short right slot: its own pair still completes, the next frame is lost.
    send_frame(24'h3C3C3C, 24'hC3C3C3, 1'b1, 32, 1'b1, 256);
    send_frame(24'h777777, 24'h888888, 1'b0, 30, 1'b1, 256);
    send_frame(24'h999999, 24'hAAAAAA, 1'b0, 32, 1'b0, 0);
    check("slot_err_set", slot_err, 1);
    check("err_state", 32'(dut.state), 32'(ALIGN));
    send_frame(24'h246810, 24'hFEDCB9, 1'b1, 32, 1'b1, 0);
    check("slot_err_sticky", slot_err, 1);

    // One-cycle reset mid left slot.
    fork
      send_frame(24'hABABAB, 24'hCDCDCD, 1'b0, 32, 1'b0, 0);
      begin
        repeat (100) @(negedge mclk);
        srst_n = 1'b0;
        @(negedge mclk);
        srst_n = 1'b1;
        check("mid_rst_left", left, 0);
        check("mid_rst_right", right, 0);
        check("mid_rst_valid", valid, 0);
        check("mid_rst_slot_err", slot_err, 0);
      end
    join
    send_frame(24'h1F2E3D, 24'h4C5B6A, 1'b0, 32, 1'b1, 0);
    send_frame(24'h700001, 24'h8FFFFE, 1'b1, 32, 1'b1, 256);

    repeat (20) @(negedge mclk);
    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
